// File: rtl/uart_pkg.sv
// Shared constants and types for the memory-mapped UART transmitter.
// Register offsets are addr[3:2] values; status indices are bit positions in STATUS.
package uart_pkg;

  localparam logic [1:0] RegTxData  = 2'd0;
  localparam logic [1:0] RegStatus  = 2'd1;
  localparam logic [1:0] RegBaudDiv = 2'd2;
  localparam logic [1:0] RegCtrl    = 2'd3;

  localparam int unsigned StatusBusyBit     = 0;
  localparam int unsigned StatusFullBit     = 1;
  localparam int unsigned StatusEmptyBit    = 2;
  localparam int unsigned StatusOverflowBit = 3;
  localparam int unsigned StatusCountLsb    = 4;

  // 100 MHz / 115200 - 1
  localparam logic [15:0] BaudResetDefault = 16'd867;

  typedef enum logic [1:0] {
    StIdle,
    StStart,
    StData,
    StStop
  } txState_t;

endpackage

// File: rtl/bus_uart_tx_if.sv
// CPU data-bus slice seen by one peripheral: decoded select, store strobe and read-back.
interface bus_uart_tx_if;
  logic        sel;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wData;
  logic [31:0] rData;

  modport master (output sel, output we, output addr, output wData, input rData);
  modport slave  (input sel, input we, input addr, input wData, output rData);
endinterface

// File: rtl/sync_fifo.sv
// Single-clock FIFO with first-word fall-through head; pushes when full and pops when
// empty are ignored.
module sync_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4,
  localparam int unsigned PtrW = (Depth > 1) ? $clog2(Depth) : 1,
  localparam int unsigned CntW = $clog2(Depth + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [Width-1:0] wData,
  output logic [Width-1:0] rData,
  output logic             full,
  output logic             empty,
  output logic [CntW-1:0]  count
);

  logic [Width-1:0] mem [Depth];
  logic [PtrW-1:0]  wrPtr;
  logic [PtrW-1:0]  rdPtr;
  logic             doPush;
  logic             doPop;

  assign full   = (count == CntW'(Depth));
  assign empty  = (count == '0);
  assign doPush = push && !full;
  assign doPop  = pop && !empty;
  assign rData  = mem[rdPtr];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wrPtr <= '0;
      rdPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + PtrW'(1);
      if (doPop)  rdPtr <= rdPtr + PtrW'(1);
      case ({doPush, doPop})
        2'b10:   count <= count + CntW'(1);
        2'b01:   count <= count - CntW'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= wData;
  end

endmodule

// File: rtl/bus_uart_tx.sv
// Memory-mapped 8N1 UART transmitter: register file, transmit FIFO, baud timer and
// frame FSM. Each bit lasts BAUDDIV+1 clocks; the divider is resampled at every bit.
module bus_uart_tx
  import uart_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH = 4,
  parameter logic [15:0] BAUD_RESET = BaudResetDefault
) (
  input  logic          clk,
  input  logic          reset,
  bus_uart_tx_if.slave  bus,
  output logic          tx,
  output logic          irq
);

  localparam int unsigned CntW = $clog2(FIFO_DEPTH + 1);

  logic [15:0]     baudDiv;
  logic            ctrlEnable;
  logic            ctrlIrqEn;
  logic            overflow;

  txState_t        state;
  logic [15:0]     bitTimer;
  logic [2:0]      bitIdx;
  logic [7:0]      shiftReg;

  logic            wrEn;
  logic [1:0]      regSel;
  logic            pushReq;
  logic            launch;
  logic            bitDone;
  logic            fifoFull;
  logic            fifoEmpty;
  logic [CntW-1:0] fifoCount;
  logic [7:0]      fifoHead;
  logic [31:0]     statusWord;
  logic [31:0]     rDataC;
  logic            unusedBits;

  assign regSel  = bus.addr[3:2];
  assign wrEn    = bus.sel && bus.we;
  assign pushReq = wrEn && (regSel == RegTxData);
  assign bitDone = (bitTimer == 16'd0);

  // A new frame starts from idle, or straight out of a finished stop bit with no gap.
  assign launch = ctrlEnable && !fifoEmpty &&
                  ((state == StIdle) || ((state == StStop) && bitDone));

  assign unusedBits = ^{bus.addr[31:4], bus.addr[1:0], bus.wData[31:16]};

  sync_fifo #(
    .Width (8),
    .Depth (FIFO_DEPTH)
  ) u_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (pushReq),
    .pop   (launch),
    .wData (bus.wData[7:0]),
    .rData (fifoHead),
    .full  (fifoFull),
    .empty (fifoEmpty),
    .count (fifoCount)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      baudDiv    <= BAUD_RESET;
      ctrlEnable <= 1'b0;
      ctrlIrqEn  <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (wrEn && (regSel == RegBaudDiv)) baudDiv <= bus.wData[15:0];
      if (wrEn && (regSel == RegCtrl)) begin
        ctrlEnable <= bus.wData[0];
        ctrlIrqEn  <= bus.wData[1];
      end
      if (wrEn && (regSel == RegStatus) && bus.wData[StatusOverflowBit]) overflow <= 1'b0;
      // Full is judged before any same-cycle pop, so the byte is lost either way.
      if (pushReq && fifoFull) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= StIdle;
      bitTimer <= 16'd0;
      bitIdx   <= 3'd0;
      shiftReg <= 8'd0;
      tx       <= 1'b1;
    end else begin
      unique case (state)
        StIdle: begin
          if (launch) begin
            state    <= StStart;
            tx       <= 1'b0;
            shiftReg <= fifoHead;
            bitTimer <= baudDiv;
          end
        end
        StStart: begin
          if (bitDone) begin
            state    <= StData;
            tx       <= shiftReg[0];
            bitIdx   <= 3'd0;
            bitTimer <= baudDiv;
          end else begin
            bitTimer <= bitTimer - 16'd1;
          end
        end
        StData: begin
          if (bitDone) begin
            bitTimer <= baudDiv;
            if (bitIdx == 3'd7) begin
              state <= StStop;
              tx    <= 1'b1;
            end else begin
              shiftReg <= shiftReg >> 1;
              tx       <= shiftReg[1];
              bitIdx   <= bitIdx + 3'd1;
            end
          end else begin
            bitTimer <= bitTimer - 16'd1;
          end
        end
        StStop: begin
          if (bitDone) begin
            if (launch) begin
              state    <= StStart;
              tx       <= 1'b0;
              shiftReg <= fifoHead;
              bitTimer <= baudDiv;
            end else begin
              state <= StIdle;
            end
          end else begin
            bitTimer <= bitTimer - 16'd1;
          end
        end
        default: state <= StIdle;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      irq <= 1'b0;
    end else begin
      irq <= ctrlIrqEn && fifoEmpty && (state == StIdle);
    end
  end

  always_comb begin
    statusWord                          = 32'd0;
    statusWord[StatusBusyBit]           = (state != StIdle);
    statusWord[StatusFullBit]           = fifoFull;
    statusWord[StatusEmptyBit]          = fifoEmpty;
    statusWord[StatusOverflowBit]       = overflow;
    statusWord[StatusCountLsb +: 3]     = 3'(fifoCount);
  end

  always_comb begin
    rDataC = 32'd0;
    if (bus.sel) begin
      case (regSel)
        RegStatus:  rDataC = statusWord;
        RegBaudDiv: rDataC = {16'd0, baudDiv};
        RegCtrl:    rDataC = {30'd0, ctrlIrqEn, ctrlEnable};
        default:    rDataC = 32'd0;
      endcase
    end
  end

  assign bus.rData = rDataC;

endmodule

// File: tb/tb_bus_uart_tx.sv
// Scoreboard bench for bus_uart_tx: accepted bytes are queued with their bit length and a
// line monitor decodes every frame on tx and compares it sample by sample.
module tb_bus_uart_tx;
  import uart_pkg::*;

  typedef struct {
    logic [7:0] data;
    int         bitClks;
  } frame_t;

  logic clk = 1'b0;
  logic reset;
  logic tx;
  logic irq;

  bus_uart_tx_if bus ();

  bus_uart_tx #(
    .FIFO_DEPTH (4),
    .BAUD_RESET (16'd867)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus),
    .tx    (tx),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  int     checks = 0;
  int     errors = 0;
  int     cyc = 0;
  bit     monOn = 1'b0;
  frame_t expQ[$];
  int     frameStarts[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Line monitor: the first low sample while idle is sample 0 of a start bit.
  frame_t monF;
  int     monBad;
  int     monBitNo;
  logic   monExp;
  initial begin
    forever begin
      @(negedge clk);
      if (monOn && reset && tx === 1'b0) begin
        frameStarts.push_back(cyc);
        checks++;
        if (expQ.size() == 0) begin
          errors++;
          $display("FAIL unexpected_frame: got a start bit at cycle %0d, expected no frame", cyc);
          repeat (20) @(negedge clk);
        end else begin
          monF   = expQ.pop_front();
          monBad = 0;
          for (int k = 0; k < 10 * monF.bitClks; k++) begin
            if (k > 0) @(negedge clk);
            monBitNo = k / monF.bitClks;
            if (monBitNo == 0)      monExp = 1'b0;
            else if (monBitNo == 9) monExp = 1'b1;
            else                    monExp = monF.data[monBitNo-1];
            if (tx !== monExp) monBad++;
          end
          if (monBad != 0) begin
            errors++;
            $display("FAIL frame_0x%0h: got %0d wrong tx samples, expected 0", monF.data, monBad);
          end
        end
      end
    end
  end

  task automatic busWrite(input logic [1:0] r, input logic [31:0] d);
    @(negedge clk);
    bus.sel   = 1'b1;
    bus.we    = 1'b1;
    bus.addr  = {28'd0, r, 2'b00};
    bus.wData = d;
    @(posedge clk);
    #1;
    bus.sel = 1'b0;
    bus.we  = 1'b0;
  endtask

  task automatic busRead(input logic [1:0] r, output logic [31:0] d);
    @(negedge clk);
    bus.sel  = 1'b1;
    bus.we   = 1'b0;
    bus.addr = {28'd0, r, 2'b00};
    #1;
    d       = bus.rData;
    bus.sel = 1'b0;
  endtask

  task automatic waitIdle(input int bound, output bit ok);
    logic [31:0] s;
    ok = 1'b0;
    for (int i = 0; i < bound; i++) begin
      busRead(RegStatus, s);
      if (!s[0] && s[2]) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  // Expected line level for the baud-change frame of 0x55 (bits toggle every bit).
  function automatic logic baudChangeLevel(input int k);
    int lens[10] = '{2, 2, 2, 8, 8, 8, 8, 8, 8, 8};
    int acc = 0;
    for (int b = 0; b < 10; b++) begin
      acc += lens[b];
      if (k < acc) return (b % 2 == 1);
    end
    return 1'b1;
  endfunction

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish by 500 us, expected finish");
    $fatal(1, "watchdog expired");
  end

  logic [31:0] st;
  int          busyCnt;
  bit          seen;
  bit          ok;
  int          bad;
  int          n;
  int          baud;
  logic [7:0]  b8;
  logic        irqAtIdle;
  logic [31:0] expSt;

  initial begin
    reset     = 1'b0;
    bus.sel   = 1'b0;
    bus.we    = 1'b0;
    bus.addr  = 32'd0;
    bus.wData = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_tx", {31'd0, tx}, 32'd1);
    check("reset_irq", {31'd0, irq}, 32'd0);
    busRead(RegStatus, st);  check("reset_status", st, 32'h4);
    busRead(RegBaudDiv, st); check("reset_baud", st, 32'd867);
    busRead(RegCtrl, st);    check("reset_ctrl", st, 32'd0);
    busRead(RegTxData, st);  check("txdata_reads_zero", st, 32'd0);
    @(negedge clk);
    reset = 1'b1;

    // Single 0xA5 frame at four clocks per bit.
    monOn = 1'b1;
    busWrite(RegBaudDiv, 32'd3);
    busWrite(RegCtrl, 32'd1);
    expQ.push_back('{8'hA5, 4});
    busWrite(RegTxData, 32'hA5);
    busyCnt = 0;
    seen    = 1'b0;
    for (int i = 0; i < 300; i++) begin
      busRead(RegStatus, st);
      if (st[0]) begin
        busyCnt++;
        seen = 1'b1;
      end else if (seen) begin
        break;
      end
    end
    check("t1_busy_clks", busyCnt, 32'd40);
    check("t1_status_after", st, 32'h4);
    repeat (2) @(negedge clk);
    check("t1_queue_drained", expQ.size(), 32'd0);

    // Overfill while disabled, then back-to-back frames.
    busWrite(RegCtrl, 32'd0);
    busWrite(RegBaudDiv, 32'd2);
    for (int i = 1; i <= 5; i++) begin
      busWrite(RegTxData, i);
      if (i <= 4) expQ.push_back('{8'(i), 3});
    end
    busRead(RegStatus, st);
    check("t2_status_full_ovf", st, 32'h4A);
    frameStarts.delete();
    busWrite(RegCtrl, 32'd1);
    waitIdle(600, ok);
    check("t2_done", {31'd0, ok}, 32'd1);
    repeat (2) @(negedge clk);
    check("t2_frames", frameStarts.size(), 32'd4);
    for (int i = 1; i < frameStarts.size(); i++)
      check("t2_no_gap", frameStarts[i] - frameStarts[i-1], 32'd30);
    check("t2_queue_drained", expQ.size(), 32'd0);
    busWrite(RegStatus, 32'h8);
    busRead(RegStatus, st);
    check("t2_ovf_cleared", st, 32'h4);

    // Push into a full FIFO in the same cycle the transmitter pops.
    busWrite(RegCtrl, 32'd0);
    busWrite(RegBaudDiv, 32'd1);
    for (int i = 0; i < 4; i++) begin
      busWrite(RegTxData, 32'h10 + i);
      expQ.push_back('{8'(8'h10 + i), 2});
    end
    busWrite(RegCtrl, 32'd1);
    busWrite(RegTxData, 32'hEE);
    busRead(RegStatus, st);
    check("t3_status_after_pop_push", st, 32'h39);
    waitIdle(600, ok);
    check("t3_done", {31'd0, ok}, 32'd1);
    repeat (2) @(negedge clk);
    check("t3_queue_drained", expQ.size(), 32'd0);
    busWrite(RegStatus, 32'h8);

    // Asynchronous reset in the middle of a data bit.
    monOn = 1'b0;
    busWrite(RegBaudDiv, 32'd3);
    busWrite(RegCtrl, 32'd1);
    busWrite(RegTxData, 32'h00);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1'b1;
    end
    check("t4_frame_started", {31'd0, seen}, 32'd1);
    repeat (6) @(negedge clk);
    check("t4_tx_in_data", {31'd0, tx}, 32'd0);
    #2;
    reset = 1'b0;
    #1;
    check("t4_tx_async_high", {31'd0, tx}, 32'd1);
    check("t4_irq_low", {31'd0, irq}, 32'd0);
    busRead(RegStatus, st);  check("t4_status", st, 32'h4);
    busRead(RegBaudDiv, st); check("t4_baud", st, 32'd867);
    busRead(RegCtrl, st);    check("t4_ctrl", st, 32'd0);
    @(negedge clk);
    reset = 1'b1;
    bad = 0;
    repeat (100) begin
      @(negedge clk);
      if (tx !== 1'b1) bad++;
    end
    check("t4_no_residual_tx", bad, 32'd0);

    // BAUDDIV rewritten during the first clock of data bit 1.
    busWrite(RegBaudDiv, 32'd1);
    busWrite(RegCtrl, 32'd1);
    busWrite(RegTxData, 32'h55);
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin
      @(negedge clk);
      if (tx === 1'b0) seen = 1'b1;
    end
    check("t5_frame_started", {31'd0, seen}, 32'd1);
    bad = 0;
    for (int k = 0; k < 62; k++) begin
      if (k > 0) @(negedge clk);
      if (tx !== baudChangeLevel(k)) bad++;
      if (k == 4) begin
        bus.sel   = 1'b1;
        bus.we    = 1'b1;
        bus.addr  = {28'd0, RegBaudDiv, 2'b00};
        bus.wData = 32'd7;
      end else if (k == 5) begin
        bus.sel = 1'b0;
        bus.we  = 1'b0;
      end
    end
    check("t5_bit_lengths", bad, 32'd0);
    waitIdle(100, ok);
    check("t5_done", {31'd0, ok}, 32'd1);

    // Interrupt on return to idle, and deselected reads.
    monOn = 1'b1;
    busWrite(RegBaudDiv, 32'd1);
    busWrite(RegCtrl, 32'd3);
    repeat (2) @(negedge clk);
    check("t6_irq_idle", {31'd0, irq}, 32'd1);
    expQ.push_back('{8'h3C, 2});
    busWrite(RegTxData, 32'h3C);
    seen      = 1'b0;
    bad       = 0;
    irqAtIdle = 1'bx;
    for (int i = 0; i < 200; i++) begin
      busRead(RegStatus, st);
      if (st[0]) begin
        seen = 1'b1;
        if (irq !== 1'b0) bad++;
      end else if (seen) begin
        irqAtIdle = irq;
        break;
      end
    end
    check("t6_irq_low_while_busy", bad, 32'd0);
    check("t6_irq_at_idle_edge", {31'd0, irqAtIdle}, 32'd0);
    @(negedge clk);
    #1;
    check("t6_irq_one_clk_later", {31'd0, irq}, 32'd1);
    @(negedge clk);
    bus.sel  = 1'b0;
    bus.we   = 1'b0;
    bus.addr = {28'd0, RegStatus, 2'b00};
    #1;
    check("t6_deselected_read", bus.rData, 32'd0);
    check("t6_queue_drained", expQ.size(), 32'd0);

    // Randomised bursts written while disabled, then drained.
    for (int it = 0; it < 6; it++) begin
      baud = $urandom_range(0, 3);
      n    = $urandom_range(1, 6);
      busWrite(RegCtrl, 32'd0);
      busWrite(RegStatus, 32'h8);
      busWrite(RegBaudDiv, baud);
      for (int j = 0; j < n; j++) begin
        b8 = 8'($urandom);
        busWrite(RegTxData, {24'd0, b8});
        if (j < 4) expQ.push_back('{b8, baud + 1});
      end
      expSt = ((n > 4 ? 4 : n) << 4) | (n > 4 ? 32'h8 : 32'h0) | (n >= 4 ? 32'h2 : 32'h0);
      busRead(RegStatus, st);
      check("rnd_status", st, expSt);
      busRead(RegBaudDiv, st);
      check("rnd_baud", st, baud);
      busWrite(RegCtrl, 32'd1);
      waitIdle(1000, ok);
      check("rnd_done", {31'd0, ok}, 32'd1);
      repeat (3) @(negedge clk);
      check("rnd_queue_drained", expQ.size(), 32'd0);
    end

    monOn = 1'b0;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bus_uart_tx.md
Name: bus_uart_tx

Overview:
- Memory-mapped UART transmitter on the CPU data bus, alongside RAM.
- Consumes CPU store transactions (busWe/busAddr/busWData) selected by an external address decoder.
- Buffers bytes in a small FIFO and serialises them as 8N1 on a single tx pin.
- Returns status and config words on the shared read-data path.

Parameters:
- FIFO_DEPTH, 4, byte entries in transmit FIFO (power of two, >=2)
- BAUD_RESET, 16'd867, reset value of BAUDDIV (100 MHz / 115200 - 1)

Ports:
- clk  input  1  system clock
- reset  input  1  asynchronous, active-low reset
- sel  input  1  address decoder select for this peripheral
- we  input  1  bus write enable, qualified by sel
- addr  input  32  bus address; only addr[3:2] decoded
- wData  input  32  bus write data
- rData  output  32  read data, combinational from addr[3:2]
- tx  output  1  serial output, idle high
- irq  output  1  high while FIFO empty and shifter idle (CTRL.irq_en gated)

Behaviour:
- Register map (addr[3:2]):
  - 0 TXDATA: write pushes wData[7:0]; reads 0.
  - 1 STATUS: [0] busy, [1] full, [2] empty, [3] overflow (sticky), [6:4] count; writing 1 to bit 3 clears overflow.
  - 2 BAUDDIV: [15:0] rw.
  - 3 CTRL: [0] enable, [1] irq_en; rw.
- Write takes effect on the rising clk when sel && we. Reads are combinational with zero wait states. rData = 0 when sel = 0.
- Reset (reset = 0, async):
  - tx = 1, irq = 0, FIFO empty, count = 0, overflow = 0
  - BAUDDIV = BAUD_RESET, CTRL = 0, state IDLE, rData reflects reset values.
- Push when full: byte dropped, overflow set. Full is sampled before any same-cycle pop, so a simultaneous pop does not admit the write.
- FSM states IDLE, START, DATA, STOP. A 16-bit down-counter is reloaded from BAUDDIV at the start of every bit, so each bit lasts BAUDDIV+1 clocks.
  - IDLE -> START when enable && !empty; pops FIFO head into shift register that cycle. tx goes 0 on the next clock.
  - START -> DATA at counter zero; bit index = 0.
  - DATA: tx = shift[0], LSB first; at counter zero shift right, index++. After index 7 completes -> STOP.
  - STOP: tx = 1 for one bit time. At end -> START with same-cycle pop if enable && !empty (no idle gap), else IDLE.
- busy = (state != IDLE).
- Clearing enable mid-frame: current frame completes; no further pops.
- BAUDDIV write mid-frame: applies from the next bit boundary.
- count saturates at FIFO_DEPTH; FIFO pointers wrap modulo FIFO_DEPTH.
- Push and pop in the same cycle (not full): count unchanged, both pointers advance.
- irq = irq_en && empty && !busy, registered, one-cycle latency.

Decomposition:
- Package uart_pkg: register offset constants, STATUS bit index constants, state enum (IDLE/START/DATA/STOP), BAUD_RESET default.
- Sub-module sync_fifo (parametric width/depth, push/pop/full/empty/count, async active-low reset).
- FSM, baud counter and register file stay in bus_uart_tx.

Test Plan:
1. BAUDDIV=3, CTRL=1, write TXDATA 0xA5 -> tx low 4 clks, then 1,0,1,0,0,1,0,1 for 4 clks each, high 4 clks; busy 40 clks total; STATUS reads empty=1 afterwards.
2. CTRL=0, write TXDATA 5 times (0x01..0x05) -> STATUS count=4, full=1, overflow=1. Enable -> bytes 0x01..0x04 sent back-to-back with no idle clocks between STOP and next START. Write 0x8 to STATUS -> overflow=0.
3. FIFO full with transmitter popping in the same cycle as a TXDATA write -> write dropped, overflow=1, count = 3 after that cycle.
4. Assert reset mid-DATA bit -> tx=1 immediately (asynchronous); STATUS=0x4; BAUDDIV reads 867; no residual transmission after release.
5. BAUDDIV=1 during a frame, written to 7 mid-bit -> current bit keeps 2-clk length, following bits 8 clks.
6. irq_en=1, send one byte -> irq=0 while busy, rises one clk after return to IDLE with FIFO empty. sel=0 read -> rData=0.
